// File: rtl/rom_bus_bridge.sv
// Bridge between the 65C02 request/ready bus and the synchronous boot ROM.
// Decodes the ROM window, inserts ROM latency plus wait states, and traps ROM writes.
module rom_bus_bridge #(
    parameter int          ROM_ADDR_BITS = 14,
    parameter logic [15:0] ROM_BASE      = 16'hC000,
    parameter int          WAIT_STATES   = 0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        cpu_valid,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_rw,
    output logic        cpu_rdy,
    output logic [7:0]  cpu_din,
    output logic        miss_sel,
    output logic        rom_enable,
    output logic        read,
    output logic [15:0] addra,
    input  logic [7:0]  douta,
    input  logic        viol_clr,
    output logic        wr_viol,
    output logic [7:0]  viol_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_CAPTURE,
        S_ACK
    } state_t;

    // Value loaded on entry to S_WAIT; unused when no wait states are configured.
    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    state_t      state_q, state_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic [15:0] addra_q, addra_d;
    logic [7:0]  din_q, din_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        viol_q, viol_d;
    logic        hit;
    logic        wr_accept;

    assign hit       = (cpu_addr[15:ROM_ADDR_BITS] == ROM_BASE[15:ROM_ADDR_BITS]);
    assign miss_sel  = cpu_valid & ~hit;
    assign wr_accept = (state_q == S_IDLE) & cpu_valid & hit & ~cpu_rw;

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        addra_d    = addra_q;
        din_d      = din_q;
        case (state_q)
            S_IDLE: begin
                if (cpu_valid && hit) begin
                    if (cpu_rw) begin
                        addra_d = cpu_addr;
                        state_d = S_ISSUE;
                    end else begin
                        state_d = S_ACK;
                    end
                end
            end
            S_ISSUE: begin
                if (WAIT_STATES == 0) begin
                    state_d = S_CAPTURE;
                end else begin
                    wait_cnt_d = WAIT_LOAD;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (wait_cnt_q == 4'd0) begin
                    state_d = S_CAPTURE;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            S_CAPTURE: begin
                din_d   = douta;
                state_d = S_ACK;
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Clear wins over a same-cycle write trap.
    always_comb begin
        viol_d = viol_q;
        cnt_d  = cnt_q;
        if (viol_clr) begin
            viol_d = 1'b0;
            cnt_d  = 8'h00;
        end else if (wr_accept) begin
            viol_d = 1'b1;
            cnt_d  = (cnt_q == 8'hFF) ? 8'hFF : cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= 4'd0;
            addra_q    <= 16'h0000;
            din_q      <= 8'h00;
            cnt_q      <= 8'h00;
            viol_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            addra_q    <= addra_d;
            din_q      <= din_d;
            cnt_q      <= cnt_d;
            viol_q     <= viol_d;
        end
    end

    assign cpu_rdy    = (state_q == S_ACK);
    assign rom_enable = (state_q == S_ISSUE);
    assign read       = (state_q == S_ISSUE);
    assign addra      = addra_q;
    assign cpu_din    = din_q;
    assign wr_viol    = viol_q;
    assign viol_cnt   = cnt_q;

endmodule
